// File: rtl/tnet_pkg.sv
// Shared TNET definitions: packet types, header field layout, broadcast ID and
// receive deframer state encoding.
package tnet_pkg;

  typedef enum logic [4:0] {
    TYPE_NOP   = 5'd0,
    TYPE_CMD   = 5'd1,
    TYPE_RESP  = 5'd2,
    TYPE_SYNC  = 5'd3,
    TYPE_EVENT = 5'd4
  } tnet_type_e;

  localparam logic [9:0] TNET_BCAST_ID = 10'h3FF;

  localparam int HDR_DST_LSB = 0;
  localparam int HDR_SRC_LSB = 10;
  localparam int HDR_OPC_LSB = 59;
  localparam int HDR_ID_W    = 10;
  localparam int HDR_OPC_W   = 5;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HDR  = 2'd1,
    RX_DROP = 2'd2
  } rx_state_e;

  function automatic logic [HDR_ID_W-1:0] hdr_dst(input logic [63:0] hdr);
    return hdr[HDR_DST_LSB +: HDR_ID_W];
  endfunction

  function automatic logic [HDR_ID_W-1:0] hdr_src(input logic [63:0] hdr);
    return hdr[HDR_SRC_LSB +: HDR_ID_W];
  endfunction

  function automatic logic [HDR_OPC_W-1:0] hdr_opc(input logic [63:0] hdr);
    return hdr[HDR_OPC_LSB +: HDR_OPC_W];
  endfunction

endpackage

// File: rtl/tnet_rx_deframer.sv
// Receive deframer: splits the link stream into 1- or 2-beat packets, filters
// them by destination/source and presents accepted commands one cycle later.
module tnet_rx_deframer
  import tnet_pkg::*;
#(
  parameter logic [9:0] BCAST_ID = TNET_BCAST_ID
) (
  input  logic             c_clk_i,
  input  logic             c_rst_ni,
  input  logic [9:0]       ID_i,
  input  logic [9:0]       NN_i,
  input  logic             rx_tvalid_i,
  input  logic [63:0]      rx_tdata_i,
  input  logic             rx_tlast_i,
  output logic             cmd_req_set_o,
  output logic [1:0][63:0] cmd_dt_o,
  output logic [31:0]      rx_status_o,
  output logic [1:0]       rx_st_do
);

  rx_state_e        state_q, state_d;
  logic [63:0]      hdr_q, hdr_d;
  logic             req_set_q, req_set_d;
  logic [1:0][63:0] dt_q, dt_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic        done;
  logic        overrun;
  logic [63:0] done_hdr;
  logic [63:0] done_data;
  logic        loopback;
  logic        hit;
  logic        range_err;
  logic        accept;
  logic        err_pkt;
  logic        drop_pkt;

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    done      = 1'b0;
    overrun   = 1'b0;
    done_hdr  = '0;
    done_data = '0;
    case (state_q)
      RX_IDLE: begin
        if (rx_tvalid_i) begin
          hdr_d = rx_tdata_i;
          if (rx_tlast_i) begin
            done     = 1'b1;
            done_hdr = rx_tdata_i;
          end else begin
            state_d = RX_HDR;
          end
        end
      end
      RX_HDR: begin
        if (rx_tvalid_i) begin
          if (rx_tlast_i) begin
            done      = 1'b1;
            done_hdr  = hdr_q;
            done_data = rx_tdata_i;
            state_d   = RX_IDLE;
          end else begin
            overrun = 1'b1;
            state_d = RX_DROP;
          end
        end
      end
      RX_DROP: begin
        if (rx_tvalid_i && rx_tlast_i) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Loop-back wins over an address hit; broadcast is never a range error.
  always_comb begin
    loopback  = (hdr_src(done_hdr) == ID_i);
    hit       = (hdr_dst(done_hdr) == ID_i) || (hdr_dst(done_hdr) == BCAST_ID);
    range_err = (hdr_dst(done_hdr) >= NN_i) && (hdr_dst(done_hdr) != BCAST_ID);
    accept    = done && !loopback && hit;
    err_pkt   = done && !loopback && !hit && range_err;
    drop_pkt  = done && !accept && !err_pkt;
  end

  always_comb begin
    req_set_d  = accept;
    dt_d       = dt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      dt_d[0]   = done_hdr;
      dt_d[1]   = done_data;
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if ((overrun || err_pkt) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    if (drop_pkt && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
    if (!c_rst_ni) begin
      state_q    <= RX_IDLE;
      hdr_q      <= '0;
      req_set_q  <= 1'b0;
      dt_q       <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      req_set_q  <= req_set_d;
      dt_q       <= dt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign cmd_req_set_o = req_set_q;
  assign cmd_dt_o      = dt_q;
  assign rx_status_o   = {err_cnt_q, drop_cnt_q, pkt_cnt_q};
  assign rx_st_do      = state_q;

endmodule

// File: doc/tnet_rx_deframer.md
TNET_RX_DEFRAMER -- requirements
Module: tnet_rx_deframer

Interface
REQ-001 SHALL have parameter BCAST_ID, default 10'h3FF, destination ID accepted by every node.
REQ-002 SHALL have ports: c_clk_i  in  1  core clock; all logic is on this clock.
REQ-003 SHALL have ports: c_rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: ID_i  in  10  local node ID; NN_i  in  10  node count.
REQ-005 SHALL have ports: rx_tvalid_i  in  1;  rx_tdata_i  in  64;  rx_tlast_i  in  1  received link stream, no backpressure.
REQ-006 SHALL have ports: cmd_req_set_o  out  1  single-cycle pulse per accepted command.
REQ-007 SHALL have ports: cmd_dt_o  out  2x64  [0] = header, [1] = data word.
REQ-008 SHALL have ports: rx_status_o  out  32  {err_cnt[7:0], drop_cnt[7:0], pkt_cnt[15:0]}.
REQ-009 SHALL have ports: rx_st_do  out  2  FSM state, debug.

Function
REQ-010 Header beat fields SHALL be: [9:0] destination ID, [19:10] source ID, [63:59] opcode; all other bits are carried unchanged.
REQ-011 A valid packet SHALL be exactly 1 beat (header only, tlast=1) or 2 beats (header, data, tlast on beat 2).
REQ-012 The FSM SHALL have states IDLE=0, HDR=1 (header held, awaiting data), DROP=2 (discard until tlast).
REQ-013 In IDLE, a beat with tvalid=1 SHALL be latched as the header.
- If tlast=1: the packet completes, data word = 0, and the state stays IDLE.
- If tlast=0: go to HDR.
REQ-014 In HDR, a beat with tvalid=1 and tlast=1 SHALL complete the packet with that beat as data, and go to IDLE.
REQ-015 In HDR, a beat with tvalid=1 and tlast=0 (overrun) SHALL increment err_cnt and go to DROP.
REQ-016 In DROP, beats SHALL be discarded; a beat with tlast=1 returns to IDLE; no counter increments.
REQ-017 Cycles with tvalid=0 SHALL not change state; gaps between beats are legal.
REQ-018 A completed packet SHALL be accepted when destination == ID_i or destination == BCAST_ID.
REQ-019 A completed packet with source == ID_i SHALL be treated as a loop-back and dropped, even if REQ-018 matches.
REQ-020 A completed packet with destination >= NN_i (and not BCAST_ID) SHALL increment err_cnt and not be accepted.
REQ-021 Any other non-accepted completed packet SHALL increment drop_cnt.
REQ-022 On acceptance:
- cmd_dt_o SHALL update and cmd_req_set_o SHALL pulse for exactly one cycle, the cycle after the completing beat (latency 1).
- pkt_cnt SHALL increment on the same cycle.
REQ-023 cmd_dt_o SHALL hold its last accepted value until the next acceptance; rejected packets SHALL never alter it.
REQ-024 pkt_cnt SHALL wrap at 2^16; err_cnt and drop_cnt SHALL saturate at 255.
REQ-025 ID_i and NN_i SHALL be sampled at the completing beat; changes mid-packet are legal.
REQ-026 Back-to-back single-beat packets on consecutive cycles SHALL each produce their own pulse, with no beat lost.

Reset
REQ-027 Assertion of c_rst_ni SHALL asynchronously force:
- state IDLE;
- cmd_req_set_o = 0, cmd_dt_o = 0;
- all counters 0, rx_st_do = 0.
REQ-028 Reset asserted mid-packet SHALL discard the partial packet; the first beat after release SHALL be parsed as a header.

Structure
REQ-029 The header field positions, BCAST_ID default and state encoding SHALL be defined in the shared tnet package alongside the existing TYPE_ types.
REQ-030 The block SHALL be a single module with no sub-modules; the counters SHALL be inline.

Verification
REQ-031 ID=3, NN=8: 1-beat header dst=3 src=1 -> 1-cycle pulse, cmd_dt_o[0]=header, [1]=0, pkt_cnt=1.
REQ-032 ID=3: 2-beat packet dst=3 with data 64'hDEAD_BEEF_0000_0001, 4 idle cycles between beats -> one pulse, cmd_dt_o[1]=64'hDEAD_BEEF_0000_0001.
REQ-033 ID=3, NN=8: packets dst=5, dst=12, src=3 -> no pulse, cmd_dt_o unchanged, drop_cnt=2, err_cnt=1.
REQ-034 3-beat packet, then 1-beat packet dst=3FF -> err_cnt=1, then one broadcast pulse, state IDLE.
REQ-035 300 overrun packets -> err_cnt=255 (saturated); 65537 accepted packets -> pkt_cnt=1.
REQ-036 Reset pulsed after a header beat, then a 1-beat dst=3 packet -> exactly one pulse with the new header.
